regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
// - Shares the register file's single write port between the pipeline writeback (P) and a long-latency writeback source (S: divider/late load).
// - P has fixed priority and is never stalled except by the starvation guard; S results queue in a DEPTH-entry FIFO.
// - Sits between the WB stage / long-latency unit and the register file write port (i_rd_wren/i_rd_addr/i_rd_data).
// PARAMETERS
// - DEPTH     4  S queue entries; power of 2, >=2
// - MAX_WAIT  8  cycles FIFO head may wait unserved before P is force-stalled; >=1
// PORTS
// - i_clk       in   1   clock; all state updates on posedge
// - i_rst_n     in   1   async active-low reset
// - i_p_wren    in   1   pipeline WB write request
// - i_p_addr    in   5   pipeline WB destination register
// - i_p_data    in   32  pipeline WB data
// - o_p_stall   out  1   P must hold i_p_* stable and freeze WB this cycle
// - i_s_valid   in   1   S result valid
// - i_s_addr    in   5   S destination register
// - i_s_data    in   32  S result data
// - o_s_ready   out  1   S beat accepted when i_s_valid & o_s_ready
// - o_rd_wren   out  1   register file write enable
// - o_rd_addr   out  5   register file write address
// - o_rd_data   out  32  register file write data
// - o_fifo_cnt  out  $clog2(DEPTH)+1  current S queue occupancy
// BEHAVIOUR
// - Reset (i_rst_n=0, async): FIFO empty, pointers/count/wait counter 0, state IDLE;
//   o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_p_stall=0, o_s_ready=0, o_fifo_cnt=0 while low.
// - Reset mid-operation: queued S entries are lost, not written; no partial write issued.
// - o_s_ready = (fifo_cnt < DEPTH), or =1 when a push and pop occur in the same cycle at full.
// - P "uses port" when i_p_wren=1 and i_p_addr!=0 and o_p_stall=0; P writes to x0 are dropped, port left free.
// - Grant per cycle, exactly one: P if P uses port; else FIFO head if non-empty; else nothing.
// - Head popped on grant; head with addr==0 popped without a write (o_rd_wren=0).
// - Collision: P uses port and head addr==i_p_addr (nonzero) -> P writes, head popped and discarded (P is younger).
// - Latency: S beat accepted in cycle N drives the write port no earlier than N+1 (registered FIFO).
// - Output mux: o_rd_* combinational from grant; o_rd_addr/o_rd_data=0 when o_rd_wren=0.
// - FSM (registered):
//   IDLE  : FIFO empty; wait_cnt=0. push -> WAIT.
//   WAIT  : head blocked by P -> wait_cnt++; head popped -> wait_cnt=0 (stay WAIT if cnt>1, else IDLE if no push).
//           wait_cnt reaches MAX_WAIT -> FORCE.
//   FORCE : o_p_stall=1 (Moore); head granted unconditionally, P ignored; exit after 1 cycle to WAIT (non-empty) or IDLE.
// - Simultaneous push+pop: count unchanged; push at full only legal with same-cycle pop.
// - Pointers wrap modulo DEPTH; o_fifo_cnt never exceeds DEPTH.
// - Worst case a queued entry is written within DEPTH*(MAX_WAIT+1) cycles of acceptance.
// CONFIGURATION
// - REGARB_BYPASS_EN defined: S beat with FIFO empty and P not using the port is written the same cycle (combinational
//   bypass, FIFO not touched, state stays IDLE).
// - REGARB_BYPASS_EN undefined: every S beat enqueues; minimum S-to-write latency 1 cycle.
// TESTING
// - Reset: assert i_rst_n=0 with 3 entries queued -> o_fifo_cnt=0, o_rd_wren=0, o_s_ready=0; after release o_s_ready=1.
// - P only: i_p_wren=1,addr=5,data=0xDEADBEEF -> same cycle o_rd_wren=1,o_rd_addr=5,o_rd_data=0xDEADBEEF; addr=0 -> o_rd_wren=0.
// - S idle port: S beat addr=7,data=0x12 at cycle N -> write x7=0x12 at N+1 (N with REGARB_BYPASS_EN); o_fifo_cnt back to 0.
// - Fill: P busy every cycle, push 4 S beats -> o_fifo_cnt=4, o_s_ready=0; 5th beat held by S, not lost.
// - Starvation: P busy continuously, 1 entry queued -> o_p_stall=1 exactly once after 8 blocked cycles, head written that cycle.
// - Collision: head addr=9, P writes x9=0xAA -> o_rd_data=0xAA, head discarded, o_fifo_cnt decrements, no later x9 write.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file's single write port between
// the pipeline writeback (P, fixed priority) and a long-latency writeback
// source (S) that is buffered in a DEPTH-entry FIFO. A starvation guard
// stalls P for one cycle when the FIFO head has been blocked MAX_WAIT cycles.
// Optional feature macro: REGARB_BYPASS_EN (same-cycle S write when the FIFO
// is empty and P leaves the port free).
module regfile_wr_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_p_wren,
  input  logic [4:0]               i_p_addr,
  input  logic [31:0]              i_p_data,
  output logic                     o_p_stall,
  input  logic                     i_s_valid,
  input  logic [4:0]               i_s_addr,
  input  logic [31:0]              i_s_data,
  output logic                     o_s_ready,
  output logic                     o_rd_wren,
  output logic [4:0]               o_rd_addr,
  output logic [31:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]   o_fifo_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic            stall_q;

  logic [4:0]      addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt, cnt_n;

  logic            fifo_empty, fifo_full;
  logic [4:0]      head_addr;
  logic [31:0]     head_data;
  logic            p_uses, head_grant, collide, head_blocked;
  logic            pop, push, bypass, s_ready;

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == FULL_CNT);
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  // P owns the port unless it targets x0 or is being force-stalled; outputs
  // are additionally held quiet while reset is asserted.
  assign p_uses       = i_rst_n & i_p_wren & (i_p_addr != '0) & ~stall_q;
  assign head_grant   = ~fifo_empty & ~p_uses;
  assign collide      = p_uses & ~fifo_empty & (head_addr == i_p_addr);
  assign head_blocked = p_uses & ~fifo_empty & ~collide;
  assign pop          = head_grant | collide;

`ifdef REGARB_BYPASS_EN
  assign bypass = i_rst_n & i_s_valid & fifo_empty & ~p_uses;
`else
  assign bypass = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign s_ready = i_rst_n & (~fifo_full | pop);
  assign push    = i_s_valid & s_ready & ~bypass;

  assign o_s_ready  = s_ready;
  assign o_p_stall  = stall_q;
  assign o_fifo_cnt = cnt;

  // Write-port mux: P first, then FIFO head (x0 heads drop silently), then bypass.
  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = '0;
    o_rd_data = '0;
    if (p_uses) begin
      o_rd_wren = 1'b1;
      o_rd_addr = i_p_addr;
      o_rd_data = i_p_data;
    end else if (head_grant) begin
      if (head_addr != '0) begin
        o_rd_wren = 1'b1;
        o_rd_addr = head_addr;
        o_rd_data = head_data;
      end
    end else if (bypass && (i_s_addr != '0)) begin
      o_rd_wren = 1'b1;
      o_rd_addr = i_s_addr;
      o_rd_data = i_s_data;
    end
  end

  // Next occupancy from push/pop.
  always_comb begin
    cnt_n = cnt;
    case ({push, pop})
      2'b10:   cnt_n = cnt + 1'b1;
      2'b01:   cnt_n = cnt - 1'b1;
      default: cnt_n = cnt;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_n;
    end
  end

  // FIFO storage; contents are meaningless while cnt is zero, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[wr_ptr] <= i_s_addr;
      data_q[wr_ptr] <= i_s_data;
    end
  end

  // Starvation-guard next-state: count cycles the head is blocked by P.
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    case (state)
      ST_IDLE: begin
        wait_n = '0;
        if (cnt_n != '0) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (head_blocked) begin
          wait_n = wait_cnt + 1'b1;
          if (wait_n == WAIT_LIM) state_n = ST_FORCE;
        end else begin
          if (pop) wait_n = '0;
          state_n = (cnt_n != '0) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_FORCE: begin
        wait_n  = '0;
        state_n = (cnt_n != '0) ? ST_WAIT : ST_IDLE;
      end
      default: begin
        wait_n  = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and the Moore stall output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      stall_q  <= (state_n == ST_FORCE);
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter (default build).
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_wren;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        p_stall;
  logic        s_valid;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        s_ready;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p_wren(p_wren), .i_p_addr(p_addr), .i_p_data(p_data), .o_p_stall(p_stall),
    .i_s_valid(s_valid), .i_s_addr(s_addr), .i_s_data(s_data), .o_s_ready(s_ready),
    .o_rd_wren(rd_wren), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_fifo_cnt(fifo_cnt)
  );

  typedef struct {
    logic        pw; logic [4:0] pa; logic [31:0] pd;
    logic        sv; logic [4:0] sa; logic [31:0] sd;
    logic        ew; logic [4:0] ea; logic [31:0] ed;
    logic [2:0]  ec; logic er; logic es;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    p_wren = pw; p_addr = pa; p_data = pd;
    s_valid = sv; s_addr = sa; s_data = sd;
  endtask

  // Advance to the next cycle's drive point (just after the rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_seen;

    // Sequence from reset, hand-computed expectations.
    //          pw pa     pd            sv sa     sd          ew ea     ed            ec    er es
    vt[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      1, 5'd5,  32'hDEADBEEF, 3'd0, 1, 0};
    vt[2]  = '{1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[3]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'h12,     0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd7,  32'h12,       3'd1, 1, 0};
    vt[5]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[6]  = '{1, 5'd3,  32'h33,       1, 5'd10, 32'h100,    1, 5'd3,  32'h33,       3'd0, 1, 0};
    vt[7]  = '{1, 5'd4,  32'h44,       1, 5'd11, 32'h111,    1, 5'd4,  32'h44,       3'd1, 1, 0};
    vt[8]  = '{1, 5'd0,  32'h99,       0, 5'd0,  32'h0,      1, 5'd10, 32'h100,      3'd2, 1, 0};
    vt[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd11, 32'h111,      3'd1, 1, 0};
    vt[10] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h55,     0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd1, 1, 0};
    vt[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[13] = '{0, 5'd0,  32'h0,        1, 5'd9,  32'h77,     0, 5'd0,  32'h0,        3'd0, 1, 0};
    vt[14] = '{1, 5'd9,  32'hAA,       0, 5'd0,  32'h0,      1, 5'd9,  32'hAA,       3'd1, 1, 0};
    vt[15] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        3'd0, 1, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_wren",  {31'b0, rd_wren}, 32'd0);
    chk("rst_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_stall", {31'b0, p_stall}, 32'd0);
    chk("rst_cnt",   {29'b0, fifo_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Table-driven directed vectors.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].pw, vt[i].pa, vt[i].pd, vt[i].sv, vt[i].sa, vt[i].sd);
      @(negedge clk);
      chk($sformatf("v%0d_wren", i),  {31'b0, rd_wren},  {31'b0, vt[i].ew});
      chk($sformatf("v%0d_addr", i),  {27'b0, rd_addr},  {27'b0, vt[i].ea});
      chk($sformatf("v%0d_data", i),  rd_data,           vt[i].ed);
      chk($sformatf("v%0d_cnt", i),   {29'b0, fifo_cnt}, {29'b0, vt[i].ec});
      chk($sformatf("v%0d_ready", i), {31'b0, s_ready},  {31'b0, vt[i].er});
      chk($sformatf("v%0d_stall", i), {31'b0, p_stall},  {31'b0, vt[i].es});
      next_cycle();
    end

    // Fill with P busy: 4 beats queue, 5th held until the forced slot frees one.
    for (int c = 1; c <= 15; c++) begin
      int unsigned sa;
      logic sv;
      sa = (c <= 5) ? (19 + c) : 24;
      sv = (c <= 10);
      drive(c <= 10, 5'd1, 32'h1, sv, 5'(sa), 32'h100 + sa);
      @(negedge clk);
      if (c == 5 || c == 9) begin
        chk($sformatf("fill_c%0d_cnt", c),   {29'b0, fifo_cnt}, 32'd4);
        chk($sformatf("fill_c%0d_ready", c), {31'b0, s_ready},  32'd0);
        chk($sformatf("fill_c%0d_stall", c), {31'b0, p_stall},  32'd0);
        chk($sformatf("fill_c%0d_addr", c),  {27'b0, rd_addr},  32'd1);
      end
      if (c == 10) begin
        chk("fill_force_stall", {31'b0, p_stall}, 32'd1);
        chk("fill_force_addr",  {27'b0, rd_addr}, 32'd20);
        chk("fill_force_data",  rd_data,          32'h114);
        chk("fill_force_ready", {31'b0, s_ready}, 32'd1);
        chk("fill_force_cnt",   {29'b0, fifo_cnt}, 32'd4);
      end
      if (c >= 11 && c <= 14) begin
        chk($sformatf("drain_c%0d_wren", c), {31'b0, rd_wren},  32'd1);
        chk($sformatf("drain_c%0d_addr", c), {27'b0, rd_addr},  32'd10 + c);
        chk($sformatf("drain_c%0d_data", c), rd_data,           32'h100 + 32'd10 + c);
        chk($sformatf("drain_c%0d_cnt", c),  {29'b0, fifo_cnt}, 32'd15 - c);
      end
      if (c == 15) begin
        chk("drain_end_wren", {31'b0, rd_wren},  32'd0);
        chk("drain_end_cnt",  {29'b0, fifo_cnt}, 32'd0);
      end
      next_cycle();
    end

    // Starvation with one queued entry: exactly one stall, on the 9th cycle after queueing.
    stall_seen = 0;
    for (int c = 1; c <= 13; c++) begin
      drive(1, 5'd1, 32'hC0 + c, c == 1, 5'd15, 32'h15);
      @(negedge clk);
      if (p_stall) stall_seen++;
      chk($sformatf("starve_c%0d_stall", c), {31'b0, p_stall}, (c == 10) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_addr", c),  {27'b0, rd_addr}, (c == 10) ? 32'd15 : 32'd1);
      if (c == 10) chk("starve_data", rd_data, 32'h15);
      next_cycle();
    end
    chk("starve_count", stall_seen, 32'd1);
    chk("starve_cnt",   {29'b0, fifo_cnt}, 32'd0);

    // Reset mid-operation with three entries queued.
    for (int c = 1; c <= 3; c++) begin
      drive(1, 5'd1, 32'h1, 1, 5'(15 + c), 32'h200 + c);
      next_cycle();
    end
    drive(1, 5'd2, 32'h2, 0, 0, 0);
    #1;
    chk("mid_pre_cnt", {29'b0, fifo_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt",   {29'b0, fifo_cnt}, 32'd0);
    chk("mid_rst_wren",  {31'b0, rd_wren},  32'd0);
    chk("mid_rst_ready", {31'b0, s_ready},  32'd0);
    chk("mid_rst_addr",  {27'b0, rd_addr},  32'd0);
    chk("mid_rst_stall", {31'b0, p_stall},  32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, s_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("post_rst_c%0d_wren", c), {31'b0, rd_wren},  32'd0);
      chk($sformatf("post_rst_c%0d_cnt", c),  {29'b0, fifo_cnt}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
